// File: rtl/sram_port_responder.sv
// sram_port_responder
//   Single-port SRAM responder for the control unit's sram_* interface, with
//   a lower-priority host port for preload/dump. One array access per cycle;
//   the CPU always wins, the host waits. Reads return after READ_LAT cycles.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   sram_ADDR/DI/EN/WE  CPU word address, write data, request, write-enable
//   sram_DO             CPU read data (holds until the next CPU read completes)
//   host_req/we/addr/wdata  host request (held until granted), direction,
//                       address, write data
//   host_gnt            host request accepted this cycle (combinational)
//   host_rvalid         one-cycle pulse, host_rdata valid
//   host_rdata          host read data (holds until the next host read completes)
//
// The array (mem) is never reset so a preloaded image survives reset; it is
// named mem for hierarchical dumps.
module sram_port_responder #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 65536,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] sram_ADDR,
  input  logic [DATA_W-1:0] sram_DI,
  input  logic              sram_EN,
  input  logic              sram_WE,
  output logic [DATA_W-1:0] sram_DO,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  // Selected access for this cycle
  logic              acc_valid;
  logic              acc_we;
  logic              acc_host;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [IDX_W-1:0]  acc_idx;

  // Read pipeline {valid, is_host, data}
  logic              pipe_vld_q  [READ_LAT];
  logic              pipe_vld_d  [READ_LAT];
  logic              pipe_host_q [READ_LAT];
  logic              pipe_host_d [READ_LAT];
  logic [DATA_W-1:0] pipe_data_q [READ_LAT];
  logic [DATA_W-1:0] pipe_data_d [READ_LAT];

  // Output registers
  logic [DATA_W-1:0] sram_do_q,     sram_do_d;
  logic [DATA_W-1:0] host_rdata_q,  host_rdata_d;
  logic              host_rvalid_q, host_rvalid_d;

  // Fixed CPU priority: the host only gets the array on idle CPU cycles.
  always_comb begin
    host_gnt  = host_req && !sram_EN && !reset;
    acc_valid = sram_EN || host_gnt;
    acc_host  = !sram_EN;
    acc_we    = sram_EN ? sram_WE   : host_we;
    acc_addr  = sram_EN ? sram_ADDR : host_addr;
    acc_wdata = sram_EN ? sram_DI   : host_wdata;
  end

  // Upper address bits are ignored: addresses wrap modulo DEPTH.
  assign acc_idx = acc_addr[IDX_W-1:0];

  if (ADDR_W > IDX_W) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^acc_addr[ADDR_W-1:IDX_W];
  end

  always_ff @(posedge clk) begin
    if (acc_valid && acc_we) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  // Stage 0 samples the array at the request edge; later stages shift.
  always_comb begin
    pipe_vld_d[0]  = acc_valid && !acc_we;
    pipe_host_d[0] = acc_host;
    pipe_data_d[0] = mem[acc_idx];
    for (int unsigned i = 1; i < READ_LAT; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_host_d[i] = pipe_host_q[i-1];
      pipe_data_d[i] = pipe_data_q[i-1];
    end
  end

  // Last pipeline stage steers the data into the owning port's register.
  always_comb begin
    sram_do_d     = sram_do_q;
    host_rdata_d  = host_rdata_q;
    host_rvalid_d = 1'b0;
    if (pipe_vld_q[READ_LAT-1]) begin
      if (pipe_host_q[READ_LAT-1]) begin
        host_rdata_d  = pipe_data_q[READ_LAT-1];
        host_rvalid_d = 1'b1;
      end else begin
        sram_do_d = pipe_data_q[READ_LAT-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < READ_LAT; i++) begin
        pipe_vld_q[i] <= 1'b0;
      end
      sram_do_q     <= '0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
    end else begin
      pipe_vld_q    <= pipe_vld_d;
      sram_do_q     <= sram_do_d;
      host_rdata_q  <= host_rdata_d;
      host_rvalid_q <= host_rvalid_d;
    end
  end

  // Payload needs no reset; it is qualified by the valid bits.
  always_ff @(posedge clk) begin
    pipe_host_q <= pipe_host_d;
    pipe_data_q <= pipe_data_d;
  end

  assign sram_DO     = sram_do_q;
  assign host_rdata  = host_rdata_q;
  assign host_rvalid = host_rvalid_q;

endmodule

// File: tb/tb_sram_port_responder.sv
// Testbench for sram_port_responder: three instances (READ_LAT 1, 2, 3;
// DEPTH 1024) share one stimulus stream and are compared every cycle with an
// event-queue reference model, plus directed table rows and sequences.
module tb_sram_port_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sram_ADDR;
  logic [31:0] sram_DI;
  logic        sram_EN, sram_WE;
  logic        host_req, host_we;
  logic [15:0] host_addr;
  logic [31:0] host_wdata;

  logic [31:0] do1, do2, do3, hrd1, hrd2, hrd3;
  logic        gnt1, gnt2, gnt3, rv1, rv2, rv3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_port_responder #(.ADDR_W(16), .DATA_W(32), .DEPTH(1024), .READ_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .sram_ADDR(sram_ADDR), .sram_DI(sram_DI),
    .sram_EN(sram_EN), .sram_WE(sram_WE), .sram_DO(do1),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(gnt1), .host_rvalid(rv1), .host_rdata(hrd1));

  sram_port_responder #(.ADDR_W(16), .DATA_W(32), .DEPTH(1024), .READ_LAT(2)) u_dut2 (
    .clk(clk), .reset(reset), .sram_ADDR(sram_ADDR), .sram_DI(sram_DI),
    .sram_EN(sram_EN), .sram_WE(sram_WE), .sram_DO(do2),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(gnt2), .host_rvalid(rv2), .host_rdata(hrd2));

  sram_port_responder #(.ADDR_W(16), .DATA_W(32), .DEPTH(1024), .READ_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .sram_ADDR(sram_ADDR), .sram_DI(sram_DI),
    .sram_EN(sram_EN), .sram_WE(sram_WE), .sram_DO(do3),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(gnt3), .host_rvalid(rv3), .host_rdata(hrd3));

  // ---------------- reference model ----------------
  // Each read becomes a pending response due at (request cycle + latency);
  // reset throws away everything pending and zeroes the visible outputs.
  typedef struct {
    int          k;
    int          due;
    bit          host;
    logic [31:0] data;
  } ev_t;

  ev_t         pend [$];
  logic [31:0] mmem [1024];
  logic [31:0] m_do  [3];
  logic [31:0] m_hrd [3];
  bit          m_rv  [3];
  int          cyc = 0;
  int          m_idx;
  bit          m_hg;
  ev_t         m_ev;

  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 3; k++) m_rv[k] = 1'b0;
    if (reset) begin
      pend.delete();
      for (int k = 0; k < 3; k++) begin
        m_do[k]  = '0;
        m_hrd[k] = '0;
      end
    end else begin
      for (int i = pend.size() - 1; i >= 0; i--) begin
        if (pend[i].due == cyc) begin
          if (pend[i].host) begin
            m_hrd[pend[i].k] = pend[i].data;
            m_rv[pend[i].k]  = 1'b1;
          end else begin
            m_do[pend[i].k] = pend[i].data;
          end
          pend.delete(i);
        end
      end
    end
    m_hg = host_req && !sram_EN && !reset;
    if (sram_EN) begin
      m_idx = int'(sram_ADDR) % 1024;
      if (sram_WE) mmem[m_idx] = sram_DI;
      else if (!reset) begin
        for (int k = 0; k < 3; k++) begin
          m_ev.k = k; m_ev.due = cyc + k + 1; m_ev.host = 1'b0; m_ev.data = mmem[m_idx];
          pend.push_back(m_ev);
        end
      end
    end else if (m_hg) begin
      m_idx = int'(host_addr) % 1024;
      if (host_we) mmem[m_idx] = host_wdata;
      else begin
        for (int k = 0; k < 3; k++) begin
          m_ev.k = k; m_ev.due = cyc + k + 1; m_ev.host = 1'b1; m_ev.data = mmem[m_idx];
          pend.push_back(m_ev);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (t=%0t): got %h, expected %h", name, $time, act, exp);
    end
  endfunction

  function automatic logic [31:0] pat(int i);
    return 32'hC0DE0000 | 32'(i);
  endfunction

  task automatic check_model();
    chk("L1 sram_DO",     do1,        m_do[0]);
    chk("L1 host_rvalid", 32'(rv1),   32'(m_rv[0]));
    chk("L1 host_rdata",  hrd1,       m_hrd[0]);
    chk("L2 sram_DO",     do2,        m_do[1]);
    chk("L2 host_rvalid", 32'(rv2),   32'(m_rv[1]));
    chk("L2 host_rdata",  hrd2,       m_hrd[1]);
    chk("L3 sram_DO",     do3,        m_do[2]);
    chk("L3 host_rvalid", 32'(rv3),   32'(m_rv[2]));
    chk("L3 host_rdata",  hrd3,       m_hrd[2]);
  endtask

  // Inputs are already set; check the grant mid-cycle, then advance one edge.
  task automatic tick();
    bit eg;
    #1;
    eg = host_req && !sram_EN && !reset;
    chk("L1 host_gnt", 32'(gnt1), 32'(eg));
    chk("L2 host_gnt", 32'(gnt2), 32'(eg));
    chk("L3 host_gnt", 32'(gnt3), 32'(eg));
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic idle_inputs();
    reset = 1'b0; sram_EN = 1'b0; sram_WE = 1'b0; sram_ADDR = '0; sram_DI = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
  endtask

  // ---------------- directed table (READ_LAT=1 instance) ----------------
  typedef struct {
    bit          rst, en, we;
    logic [15:0] addr;
    logic [31:0] di;
    bit          hreq, hwe;
    logic [15:0] haddr;
    logic [31:0] hwd;
    bit          gnt;
    logic [31:0] do_e;
    bit          rv;
    logic [31:0] hrd;
  } vec_t;

  function automatic vec_t mk(bit rst, bit en, bit we, logic [15:0] addr, logic [31:0] di,
                              bit hreq, bit hwe, logic [15:0] haddr, logic [31:0] hwd,
                              bit gnt, logic [31:0] do_e, bit rv, logic [31:0] hrd);
    vec_t v;
    v.rst = rst; v.en = en; v.we = we; v.addr = addr; v.di = di;
    v.hreq = hreq; v.hwe = hwe; v.haddr = haddr; v.hwd = hwd;
    v.gnt = gnt; v.do_e = do_e; v.rv = rv; v.hrd = hrd;
    return v;
  endfunction

  vec_t tbl [17];
  bit   granted;

  initial begin
    tbl[0]  = mk(0,1,0,16'h0007,0,            0,0,0,0,                    0, 32'h0,       0, 32'h0);
    tbl[1]  = mk(0,0,0,0,0,                   0,0,0,0,                    0, pat(7),      0, 32'h0);
    tbl[2]  = mk(1,0,0,0,0,                   1,0,16'h0003,0,             0, 32'h0,       0, 32'h0);
    tbl[3]  = mk(1,0,0,0,0,                   1,0,16'h0003,0,             0, 32'h0,       0, 32'h0);
    tbl[4]  = mk(0,1,0,16'h0005,0,            1,0,16'h0003,0,             0, 32'h0,       0, 32'h0);
    tbl[5]  = mk(0,1,1,16'h0010,32'h12345678, 1,0,16'h0003,0,             0, 32'hDEADBEEF,0, 32'h0);
    tbl[6]  = mk(0,1,0,16'h0010,0,            1,0,16'h0003,0,             0, 32'hDEADBEEF,0, 32'h0);
    tbl[7]  = mk(0,0,0,0,0,                   1,0,16'h0003,0,             1, 32'h12345678,0, 32'h0);
    tbl[8]  = mk(0,0,0,0,0,                   0,0,0,0,                    0, 32'h12345678,1, pat(3));
    tbl[9]  = mk(0,0,0,0,0,                   1,1,16'h0400,32'hA5A5A5A5,  1, 32'h12345678,0, pat(3));
    tbl[10] = mk(0,1,0,16'h0000,0,            0,0,0,0,                    0, 32'h12345678,0, pat(3));
    tbl[11] = mk(0,1,1,16'h0401,32'h11111111, 1,0,16'h0001,0,             0, 32'hA5A5A5A5,0, pat(3));
    tbl[12] = mk(0,0,0,0,0,                   1,0,16'h0001,0,             1, 32'hA5A5A5A5,0, pat(3));
    tbl[13] = mk(0,1,0,16'h0001,0,            0,0,0,0,                    0, 32'hA5A5A5A5,1, 32'h11111111);
    tbl[14] = mk(0,0,1,16'h0002,32'hFFFFFFFF, 0,0,0,0,                    0, 32'h11111111,0, 32'h11111111);
    tbl[15] = mk(0,1,0,16'h0002,0,            0,0,0,0,                    0, 32'h11111111,0, 32'h11111111);
    tbl[16] = mk(0,0,0,0,0,                   0,0,0,0,                    0, pat(2),      0, 32'h11111111);

    // Reset with a pending host request: no grant, outputs zero.
    idle_inputs();
    reset = 1'b1; host_req = 1'b1; host_addr = 16'h0003;
    tick();
    tick();
    chk("reset sram_DO",     do1,        32'h0);
    chk("reset host_rdata",  hrd1,       32'h0);
    chk("reset host_rvalid", 32'(rv1),   32'h0);

    // Preload the whole array through the host port.
    idle_inputs();
    for (int i = 0; i < 1024; i++) begin
      host_req = 1'b1; host_we = 1'b1; host_addr = 16'(i);
      host_wdata = (i == 5) ? 32'hDEADBEEF : pat(i);
      tick();
    end
    idle_inputs();

    for (int r = 0; r < 17; r++) begin
      reset = tbl[r].rst; sram_EN = tbl[r].en; sram_WE = tbl[r].we;
      sram_ADDR = tbl[r].addr; sram_DI = tbl[r].di;
      host_req = tbl[r].hreq; host_we = tbl[r].hwe;
      host_addr = tbl[r].haddr; host_wdata = tbl[r].hwd;
      #1;
      chk($sformatf("tbl[%0d] host_gnt", r), 32'(gnt1), 32'(tbl[r].gnt));
      tick();
      chk($sformatf("tbl[%0d] sram_DO", r),     do1,      tbl[r].do_e);
      chk($sformatf("tbl[%0d] host_rvalid", r), 32'(rv1), 32'(tbl[r].rv));
      chk($sformatf("tbl[%0d] host_rdata", r),  hrd1,     tbl[r].hrd);
    end

    // Arbitration: host read of 3 starved by 4 CPU writes, granted on the 5th.
    idle_inputs();
    host_req = 1'b1; host_addr = 16'h0003;
    for (int c = 0; c < 4; c++) begin
      sram_EN = 1'b1; sram_WE = 1'b1; sram_ADDR = 16'(32 + c); sram_DI = 32'(c);
      #1;
      chk("arb starved host_gnt", 32'(gnt1), 32'h0);
      tick();
    end
    sram_EN = 1'b0; sram_WE = 1'b0;
    #1;
    chk("arb granted host_gnt", 32'(gnt1), 32'h1);
    tick();
    host_req = 1'b0;
    chk("arb L1 rvalid early", 32'(rv1), 32'h0);
    tick();
    chk("arb L1 rvalid", 32'(rv1), 32'h1);
    chk("arb L1 rdata",  hrd1,     pat(3));
    chk("arb L2 rvalid early", 32'(rv2), 32'h0);
    tick();
    chk("arb L1 rvalid drop", 32'(rv1), 32'h0);
    chk("arb L2 rvalid", 32'(rv2), 32'h1);
    chk("arb L2 rdata",  hrd2,     pat(3));
    tick();
    chk("arb L3 rvalid", 32'(rv3), 32'h1);
    chk("arb L3 rdata",  hrd3,     pat(3));

    // Pipelined CPU reads of 1,2,3 on the READ_LAT=3 instance.
    idle_inputs();
    for (int a = 1; a <= 3; a++) begin
      sram_EN = 1'b1; sram_ADDR = 16'(a);
      tick();
    end
    idle_inputs();
    chk("pipe L3 before data", do3, pat(2));
    tick();
    chk("pipe L3 first",  do3, 32'h11111111);
    tick();
    chk("pipe L3 second", do3, pat(2));
    tick();
    chk("pipe L3 third",  do3, pat(3));

    // Reset the cycle after a host read is accepted: no response on READ_LAT=2.
    idle_inputs();
    host_req = 1'b1; host_addr = 16'h0003;
    tick();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("rst-mid L2 rvalid", 32'(rv2), 32'h0);
      chk("rst-mid L2 rdata",  hrd2,     32'h0);
      tick();
    end

    // Randomized traffic against the reference model.
    idle_inputs();
    for (int n = 0; n < 4000; n++) begin
      reset     = ($urandom_range(0, 79) == 0);
      sram_EN   = ($urandom_range(0, 1) == 1);
      sram_WE   = ($urandom_range(0, 1) == 1);
      sram_ADDR = 16'($urandom_range(0, 31) + 1024 * $urandom_range(0, 63));
      sram_DI   = $urandom;
      if (!host_req && $urandom_range(0, 2) != 0) begin
        host_req   = 1'b1;
        host_we    = ($urandom_range(0, 1) == 1);
        host_addr  = 16'($urandom_range(0, 31) + 1024 * $urandom_range(0, 63));
        host_wdata = $urandom;
      end
      granted = host_req && !sram_EN && !reset;
      tick();
      if (granted) host_req = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
